// File: rtl/au_sum_zero_det_seq_pkg.sv
// Shared types for the sequential sum-is-zero detector.
package au_sum_zero_det_seq_pkg;

  // Controller states: waiting for an operand, walking slices, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/au_sum_zero_det_slice.sv
// One SLICE-bit adder step: reports whether the slice sum is zero and its carry-out.
module au_sum_zero_det_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic             zero,
  output logic             co
);

  logic [SLICE:0] sum;

  assign sum  = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};
  assign zero = (sum[SLICE-1:0] == '0);
  assign co   = sum[SLICE];

endmodule

// File: rtl/au_sum_zero_det_seq.sv
// Sequential detector for (a + b + ci) mod 2^WIDTH == 0, SLICE bits per cycle,
// also producing the carry-out of the full addition.
//
// Optional feature: define AU_SUM_ZERO_DET_SEQ_EARLY_EXIT_EN to stop walking
// slices as soon as one slice sum is nonzero (z=0; co only meaningful when the
// exit happens on the last slice, otherwise 0).
//
// Handshake: an operand is taken on a rising edge with in_valid && in_ready
// (in_ready=1 only in IDLE). A result is presented with out_valid=1 and held,
// z/co stable, until a rising edge with out_valid && out_ready. in_valid is
// ignored while a result is being computed or held.
module au_sum_zero_det_seq
  import au_sum_zero_det_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             z,
  output logic             co,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = $clog2(NSLICE);
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  state_t          state;
  state_t          state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic            carry;
  logic            zacc;
  logic [KW-1:0]   k;
  logic            s_zero;
  logic            s_co;

  // Operands are shifted right each RUN cycle, so the current slice is always
  // the low SLICE bits and a single adder slice serves every step.
  au_sum_zero_det_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_q[SLICE-1:0]),
    .b    (b_q[SLICE-1:0]),
    .ci   (carry),
    .zero (s_zero),
    .co   (s_co)
  );

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN: begin
        if (k == K_LAST) state_nxt = DONE;
`ifdef AU_SUM_ZERO_DET_SEQ_EARLY_EXIT_EN
        if (!s_zero) state_nxt = DONE;
`endif
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and slice-walking datapath; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      zacc  <= 1'b0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= ci;
            zacc  <= 1'b1;
            k     <= '0;
          end
        end
        RUN: begin
          a_q   <= a_q >> SLICE;
          b_q   <= b_q >> SLICE;
          k     <= k + KW'(1);
          zacc  <= zacc & s_zero;
          carry <= s_co;
`ifdef AU_SUM_ZERO_DET_SEQ_EARLY_EXIT_EN
          // Bailing out early: carry is only the true carry-out on the last slice.
          if (!s_zero) begin
            zacc  <= 1'b0;
            carry <= (k == K_LAST) ? s_co : 1'b0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign z         = out_valid & zacc;
  assign co        = out_valid & carry;

endmodule

// File: tb/tb_au_sum_zero_det_seq.sv
// Self-checking bench for au_sum_zero_det_seq (WIDTH=32, SLICE=8).
module tb_au_sum_zero_det_seq;

  localparam int W      = 32;
  localparam int NSLICE = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         out_valid;
  logic         out_ready;
  logic         z;
  logic         co;
  logic         busy;

  int checks = 0;
  int fails  = 0;

  // Expected {z, co} per accepted operand, in order.
  logic [1:0] exp_q[$];

  au_sum_zero_det_seq #(.WIDTH(W), .SLICE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .co        (co),
    .busy      (busy)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: {co, sum} = a + b + ci, z = (sum == 0).
  function automatic logic [1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic civ);
    logic [W:0] s;
    logic       zz;
    logic       cc;
    s  = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, civ};
    zz = (s[W-1:0] == '0);
    cc = s[W];
`ifdef AU_SUM_ZERO_DET_SEQ_EARLY_EXIT_EN
    // Exit before the last slice reports co=0.
    if (s[W-9:0] != '0) cc = 1'b0;
`endif
    return {zz, cc};
  endfunction

  // Driver: wait for in_ready (bounded), present one operand for one edge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic civ);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; fails++;
      $display("FAIL send_ready: in_ready=%b required 1 within 20 cycles", in_ready);
    end
    a = av; b = bv; ci = civ; in_valid = 1'b1;
    exp_q.push_back(model(av, bv, civ));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Driver: advance until out_valid (bounded); lat counts cycles after acceptance edge.
  task automatic wait_result(output int lat, output logic got);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    got = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (z !== 1'b0) begin fails++; $display("FAIL reset_z: got %b want 0", z); end
    checks++; if (co !== 1'b0) begin fails++; $display("FAIL reset_co: got %b want 0", co); end
    rst = 1'b0;
  endtask

  task automatic test_zero_latency();
    int lat; logic got; logic [1:0] exp;
    send(32'h0, 32'h0, 1'b0);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL zero_busy: got %b want 1", busy); end
    wait_result(lat, got);
    exp = exp_q.pop_front();
    checks++; if (!got) begin fails++; $display("FAIL zero_timeout: out_valid=%b want 1", out_valid); end
    checks++; if (lat != NSLICE + 1) begin fails++; $display("FAIL zero_latency: got %0d want %0d", lat, NSLICE + 1); end
    checks++; if ({z, co} !== exp) begin fails++; $display("FAIL zero_result: got z=%b co=%b want %b", z, co, exp); end
    checks++; if (exp !== 2'b10) begin fails++; $display("FAIL zero_model: got %b want 10", exp); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL zero_idle: in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_wrap();
    int lat; logic got; logic [1:0] exp;
    logic [W-1:0] ta[3];
    logic [W-1:0] tb_[3];
    logic         tc[3];
    ta[0] = 32'hFFFF_FFFF; tb_[0] = 32'h0;         tc[0] = 1'b1;
    ta[1] = 32'h1234_5678; tb_[1] = 32'hEDCB_A988; tc[1] = 1'b0;
    ta[2] = 32'hFFFF_FFFF; tb_[2] = 32'hFFFF_FFFF; tc[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(ta[i], tb_[i], tc[i]);
      wait_result(lat, got);
      exp = exp_q.pop_front();
      checks++; if (!got) begin fails++; $display("FAIL wrap%0d_timeout: out_valid=%b want 1", i, out_valid); end
      checks++; if ({z, co} !== exp) begin fails++; $display("FAIL wrap%0d_result: got z=%b co=%b want %b", i, z, co, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_early_exit();
    int lat; logic got; logic [1:0] exp; int want_lat;
`ifdef AU_SUM_ZERO_DET_SEQ_EARLY_EXIT_EN
    want_lat = 2;
`else
    want_lat = NSLICE + 1;
`endif
    send(32'h1, 32'h0, 1'b0);
    wait_result(lat, got);
    exp = exp_q.pop_front();
    checks++; if (!got) begin fails++; $display("FAIL early_timeout: out_valid=%b want 1", out_valid); end
    checks++; if (lat != want_lat) begin fails++; $display("FAIL early_latency: got %0d want %0d", lat, want_lat); end
    checks++; if ({z, co} !== 2'b00) begin fails++; $display("FAIL early_result: got z=%b co=%b want 00", z, co); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat; logic got; logic [1:0] exp;
    send(32'hFFFF_FF00, 32'h0000_0100, 1'b0);
    wait_result(lat, got);
    exp = exp_q.pop_front();
    checks++; if (!got) begin fails++; $display("FAIL bp_timeout: out_valid=%b want 1", out_valid); end
    out_ready = 1'b0;
    in_valid  = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1; ci = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if ({z, co} !== exp) begin fails++; $display("FAIL bp_hold%0d: got z=%b co=%b want %b", i, z, co, exp); end
      checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid%0d: got %b want 1", i, out_valid); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_release: busy=%b in_ready=%b want 0/1", busy, in_ready); end
    repeat (3) @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_no_accept: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic got; logic [1:0] exp;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_run_busy: got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_run_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_run_in_ready: got %b want 1", in_ready); end
    send(32'h0, 32'h0, 1'b0);
    wait_result(lat, got);
    exp = exp_q.pop_front();
    checks++; if (!got || lat != NSLICE + 1) begin fails++; $display("FAIL rst_run_latency: got %0d want %0d", lat, NSLICE + 1); end
    checks++; if ({z, co} !== exp) begin fails++; $display("FAIL rst_run_result: got z=%b co=%b want %b", z, co, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat; logic got; logic [1:0] exp;
    logic [W-1:0] ra; logic [W-1:0] rb; logic rc;
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rb = -ra - {{(W-1){1'b0}}, rc};
        1: begin ra = '1; rb = '0; end
        default: ;
      endcase
      send(ra, rb, rc);
      wait_result(lat, got);
      exp = exp_q.pop_front();
      checks++;
      if (!got || {z, co} !== exp) begin
        fails++;
        $display("FAIL random%0d: a=%h b=%h ci=%b got v=%b z=%b co=%b want %b", i, ra, rb, rc, got, z, co, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  // Test sequence and final report
  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; out_ready = 1'b1;
    test_reset();
    test_zero_latency();
    test_wrap();
    test_early_exit();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/au_sum_zero_det_seq.md
AU_SUM_ZERO_DET_SEQ -- requirements
Module: AU_sum_zero_det_seq

Interface
REQ-001 Parameter WIDTH, default 32, meaning operand word length; SHALL be a multiple of SLICE.
REQ-002 Parameter SLICE, default 8, meaning bits processed per cycle; NSLICE = WIDTH/SLICE SHALL be >= 2.
REQ-003 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be, in this order:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, operand request.
- in_ready, output, 1, block can accept.
- a, input, WIDTH, operand.
- b, input, WIDTH, operand.
- ci, input, 1, carry-in.
- out_valid, output, 1, result held.
- out_ready, input, 1, consumer accepts.
- z, output, 1, flag: (a+b+ci) mod 2^WIDTH == 0.
- co, output, 1, carry-out of a+b+ci.
- busy, output, 1, state != IDLE.

Function
REQ-005 FSM states SHALL be IDLE, RUN, DONE.
REQ-006 in_ready SHALL be 1 only in IDLE; acceptance is in_valid && in_ready at a rising edge.
REQ-007 On acceptance the block SHALL register a, b and ci, clear the slice index to 0, set the zero accumulator to 1, and go to RUN.
REQ-008 Each RUN cycle SHALL process slice k (bits k*SLICE+SLICE-1 : k*SLICE, LSB first) with the carry register as carry-in.
- zacc <= zacc & (slice sum == 0).
- carry <= slice carry-out.
- k <= k+1.
REQ-009 After slice NSLICE-1 the FSM SHALL go to DONE; with out_valid=1, z=zacc and co=carry.
REQ-010 Latency SHALL be exactly NSLICE+1 cycles from the acceptance edge to the first cycle with out_valid=1 (early exit disabled).
REQ-011 In DONE, z and co SHALL hold stable while out_ready=0; out_valid && out_ready SHALL return the FSM to IDLE at that edge.
REQ-012 in_valid during RUN or DONE SHALL be ignored (no acceptance, no state change); the next request is accepted no earlier than the first IDLE cycle.
REQ-013 Full-sum wrap-around SHALL be exact:
- a=2^WIDTH-1, b=0, ci=1 gives z=1, co=1.
- 2*(2^WIDTH-1)+1 gives z=0, co=1.
REQ-014 z and co SHALL be 0 whenever out_valid=0.

Reset
REQ-015 rst=1 SHALL take priority over all other inputs at any edge, including mid-RUN and in DONE with out_ready=0. It forces:
- state IDLE.
- in_ready=1, out_valid=0, busy=0, z=0, co=0.
- slice index, carry and zacc to 0.
REQ-016 The first post-reset edge with in_valid=1 SHALL be accepted.

Configuration
REQ-017 Macro AU_SUM_ZERO_DET_SEQ_EARLY_EXIT_EN SHALL control early exit.
- Defined: when a slice sum is nonzero, the FSM enters DONE at the next edge with z=0. co SHALL equal the slice carry-out at that point, valid only when exit occurs on slice NSLICE-1, otherwise 0.
- Undefined: all NSLICE slices are always processed and co is always the true carry-out.

Structure
REQ-018 Package AU_sum_zero_det_seq_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE, 2-bit).
REQ-019 One sub-module AU_sum_zero_det_slice (SLICE-bit a, b, ci in; zero flag and carry-out combinational out) SHALL implement the per-slice datapath. It is instantiated once and reused every cycle.

Verification
REQ-020 The bench SHALL cover these scenarios, with WIDTH=32, SLICE=8 and early exit off unless stated:
- a=0, b=0, ci=0 accepted at cycle 0 -> out_valid at cycle 5, z=1, co=0.
- a=32'hFFFF_FFFF, b=0, ci=1 -> z=1, co=1; a=32'h1234_5678, b=32'hEDCB_A988, ci=0 -> z=1, co=1.
- a=1, b=0, ci=0, macro defined -> out_valid 2 cycles after acceptance, z=0, co=0.
- Result ready, out_ready=0 for 5 cycles with in_valid=1 throughout -> z/co stable, in_ready=0, no acceptance; out_ready=1 -> IDLE next cycle.
- rst=1 at cycle 2 of RUN -> next cycle IDLE, out_valid=0, in_ready=1. A new request then yields the correct result with no stale carry.
- 10000 random {a,b,ci} -> z, co match the behavioural model {co, sum} = a+b+ci, z = (sum == 0).
